// File: rtl/hwpe_stream_demux_sched_pkg.sv
// hwpe_stream_demux_sched_pkg: FSM state encodings and select-width helper for the demux scheduler
package hwpe_stream_demux_sched_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hwpe_stream_demux_sched_next_sel.sv
// hwpe_stream_demux_sched_next_sel: next enabled output after sel (wrapping) and lowest enabled output
module hwpe_stream_demux_sched_next_sel #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [SW-1:0] sel,
  input  logic [N-1:0]  mask,
  output logic [SW-1:0] nxt,
  output logic [SW-1:0] first
);
  logic [SW-1:0] idx;
  always_comb begin
    nxt = sel;
    first = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SW'((int'(sel) + k) % N);
      if (mask[idx]) nxt = idx;
    end
    for (int k = N - 1; k >= 0; k--)
      if (mask[SW'(k)]) first = SW'(k);
  end
endmodule

// File: rtl/hwpe_stream_demux_sched.sv
// hwpe_stream_demux_sched: round-robin burst select sequencer for a static stream demux
// Optional HWPE_STREAM_DEMUX_SCHED_MASK_EN adds out_mask_i to skip disabled outputs.
module hwpe_stream_demux_sched
  import hwpe_stream_demux_sched_pkg::*;
#(
  parameter int NB_OUT_STREAMS = 2,
  parameter int BURST_CNT_W    = 16,
  parameter int JOB_CNT_W      = 16,
  localparam int SEL_W         = sel_w(NB_OUT_STREAMS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [BURST_CNT_W-1:0]    burst_len_i,
  input  logic [JOB_CNT_W-1:0]      nb_bursts_i,
  input  logic                      push_valid_i,
  input  logic                      push_ready_i,
`ifdef HWPE_STREAM_DEMUX_SCHED_MASK_EN
  input  logic [NB_OUT_STREAMS-1:0] out_mask_i,
`endif
  output logic [SEL_W-1:0]          sel_o,
  output logic                      gate_o,
  output logic                      busy_o,
  output logic                      done_o
);
  logic [1:0]                state;
  logic [SEL_W-1:0]          sel_q, nxt, first;
  logic                      gate_q, busy_q, done_q;
  logic [BURST_CNT_W-1:0]    beat_cnt, len_q;
  logic [JOB_CNT_W-1:0]      burst_cnt, nb_q;
  logic [NB_OUT_STREAMS-1:0] mask_q, mask_in, mask_cur;
  logic                      beat, end_burst, last_burst;
`ifdef HWPE_STREAM_DEMUX_SCHED_MASK_EN
  assign mask_in = (|out_mask_i) ? out_mask_i : '1;
`else
  assign mask_in = '1;
`endif
  // in IDLE the select helper sees the incoming mask so the first index is ready at start
  assign mask_cur   = (state == IDLE) ? mask_in : mask_q;
  assign beat       = push_valid_i & push_ready_i & gate_q;
  assign end_burst  = beat_cnt == len_q - BURST_CNT_W'(1);
  assign last_burst = burst_cnt == nb_q - JOB_CNT_W'(1);

  hwpe_stream_demux_sched_next_sel #(.N(NB_OUT_STREAMS), .SW(SEL_W)) u_next_sel (
    .sel   (sel_q),
    .mask  (mask_cur),
    .nxt   (nxt),
    .first (first)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state     <= IDLE;
      sel_q     <= '0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      len_q     <= '0;
      nb_q      <= '0;
      mask_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          len_q     <= (burst_len_i == '0) ? BURST_CNT_W'(1) : burst_len_i;
          nb_q      <= nb_bursts_i;
          mask_q    <= mask_in;
          beat_cnt  <= '0;
          burst_cnt <= '0;
          sel_q     <= first;
          if (nb_bursts_i != '0) begin
            state  <= RUN;
            gate_q <= 1'b1;
            busy_q <= 1'b1;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        RUN: if (beat) begin
          if (end_burst) begin
            beat_cnt  <= '0;
            burst_cnt <= burst_cnt + JOB_CNT_W'(1);
            sel_q     <= nxt;
            if (last_burst) begin
              state  <= DONE;
              gate_q <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            beat_cnt <= beat_cnt + BURST_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_o  = sel_q;
  assign gate_o = gate_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_hwpe_stream_demux_sched.sv
// tb_hwpe_stream_demux_sched: directed checks of the demux scheduler on N=2, N=3 and N=4 instances
module tb_hwpe_stream_demux_sched;
  logic        clk = 1'b0;
  logic        rst, clr, s2, s3, s4, valid, ready;
  logic [15:0] cfg_len, cfg_nb;
  logic [3:0]  cfg_mask;
  logic        sel2;
  logic [1:0]  sel3, sel4, sel_m;
  logic        gate2, gate3, gate4, busy2, busy3, busy4, done2, done3, done4;
  logic        gate_m, busy_m, done_m;
  int          cur = 2;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  hwpe_stream_demux_sched #(.NB_OUT_STREAMS(2)) u2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(s2), .burst_len_i(cfg_len),
    .nb_bursts_i(cfg_nb), .push_valid_i(valid), .push_ready_i(ready),
`ifdef HWPE_STREAM_DEMUX_SCHED_MASK_EN
    .out_mask_i(cfg_mask[1:0]),
`endif
    .sel_o(sel2), .gate_o(gate2), .busy_o(busy2), .done_o(done2));

  hwpe_stream_demux_sched #(.NB_OUT_STREAMS(3)) u3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(s3), .burst_len_i(cfg_len),
    .nb_bursts_i(cfg_nb), .push_valid_i(valid), .push_ready_i(ready),
`ifdef HWPE_STREAM_DEMUX_SCHED_MASK_EN
    .out_mask_i(cfg_mask[2:0]),
`endif
    .sel_o(sel3), .gate_o(gate3), .busy_o(busy3), .done_o(done3));

  hwpe_stream_demux_sched #(.NB_OUT_STREAMS(4)) u4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(s4), .burst_len_i(cfg_len),
    .nb_bursts_i(cfg_nb), .push_valid_i(valid), .push_ready_i(ready),
`ifdef HWPE_STREAM_DEMUX_SCHED_MASK_EN
    .out_mask_i(cfg_mask),
`endif
    .sel_o(sel4), .gate_o(gate4), .busy_o(busy4), .done_o(done4));

  always_comb begin
    sel_m  = (cur == 2) ? {1'b0, sel2} : (cur == 3) ? sel3 : sel4;
    gate_m = (cur == 2) ? gate2 : (cur == 3) ? gate3 : gate4;
    busy_m = (cur == 2) ? busy2 : (cur == 3) ? busy3 : busy4;
    done_m = (cur == 2) ? done2 : (cur == 3) ? done3 : done4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    s2 = v && cur == 2;
    s3 = v && cur == 3;
    s4 = v && cur == 4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one job; expected select comes from the list of enabled outputs, one entry per burst.
  task automatic job(input int inst, input int len, input int nb, input int n,
                     input logic [3:0] m, input logic [31:0] rdy, input int inj);
    int en[$];
    int b, cyc, le;
    logic [3:0] mm, lim;
    lim = 4'((1 << n) - 1);
    mm = ((m & lim) == 4'd0) ? lim : (m & lim);
    for (int k = 0; k < n; k++) if (mm[k]) en.push_back(k);
    le = (len == 0) ? 1 : len;
    cur = inst;
    cfg_len = 16'(len);
    cfg_nb = 16'(nb);
    cfg_mask = m;
    valid = 1'b1;
    ready = 1'b1;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    chk("job_busy", busy_m, 1);
    chk("job_gate", gate_m, 1);
    b = 0;
    cyc = 0;
    while (b < le * nb && cyc < 400) begin
      chk("job_sel", sel_m, en[(b / le) % en.size()]);
      chk("job_gate_run", gate_m, 1);
      chk("job_no_done", done_m, 0);
      ready = rdy[cyc % 32];
      if (cyc == inj) begin
        set_start(1'b1);
        cfg_len = 16'd1;
        cfg_nb = 16'd9;
      end
      tick();
      set_start(1'b0);
      if (ready) b++;
      cyc++;
    end
    chk("job_beats", b, le * nb);
    chk("job_done", done_m, 1);
    chk("job_gate_off", gate_m, 0);
    chk("job_busy_off", busy_m, 0);
    ready = 1'b1;
    tick();
    chk("job_done_pulse", done_m, 0);
    chk("job_gate_idle", gate_m, 0);
    chk("job_sel_hold", sel_m, en[nb % en.size()]);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    s2 = 1'b0;
    s3 = 1'b0;
    s4 = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    cfg_len = '0;
    cfg_nb = '0;
    cfg_mask = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_sel2", sel2, 0);
    chk("rst_gate2", gate2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_done2", done2, 0);
    chk("rst_sel4", sel4, 0);
    job(2, 4, 3, 2, 4'd0, 32'hFFFF_FFFF, -1);
    job(3, 1, 7, 3, 4'd0, 32'hB5D3_6A9F, -1);
    job(3, 0, 3, 3, 4'd0, 32'hFFFF_FFFF, -1);
    // zero bursts: straight to DONE without ever opening the gate
    cur = 2;
    cfg_len = 16'd4;
    cfg_nb = 16'd0;
    s2 = 1'b1;
    tick();
    s2 = 1'b0;
    chk("nb0_done", done2, 1);
    chk("nb0_gate", gate2, 0);
    chk("nb0_busy", busy2, 0);
    tick();
    chk("nb0_done_end", done2, 0);
    chk("nb0_busy_end", busy2, 0);
    // clear on the fifth beat aborts the job silently
    cfg_len = 16'd4;
    cfg_nb = 16'd4;
    valid = 1'b1;
    ready = 1'b1;
    s2 = 1'b1;
    tick();
    s2 = 1'b0;
    repeat (4) tick();
    chk("clr_sel_b5", sel2, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_sel", sel2, 0);
    chk("clr_gate", gate2, 0);
    chk("clr_busy", busy2, 0);
    chk("clr_done", done2, 0);
    tick();
    chk("clr_no_done", done2, 0);
    job(2, 4, 4, 2, 4'd0, 32'hFFFF_FFFF, -1);
    job(2, 2, 2, 2, 4'd0, 32'hFFFF_FFFF, 1);
`ifdef HWPE_STREAM_DEMUX_SCHED_MASK_EN
    job(4, 2, 4, 4, 4'b1010, 32'hFFFF_FFFF, -1);
    job(4, 1, 4, 4, 4'b0000, 32'hFFFF_FFFF, -1);
`else
    job(4, 1, 5, 4, 4'b0000, 32'hFFFF_FFFF, -1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
